fifo_puerto: RTL and testbench

FIFO_PUERTO -- requirements
Module: fifo_puerto

---
 rtl/fifo_puerto_if.sv | 29 ++
 rtl/fifo_puerto.sv | 92 +++++++++
 tb/tb_fifo_puerto.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_puerto_if.sv
// Producer/consumer bundle for fifo_puerto: write and read requests in, data and status flags out.
interface fifo_puerto_if #(
    parameter int FIFO_WORD_SIZE = 10,
    parameter int FIFO_DEPTH     = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                      push;
    logic [FIFO_WORD_SIZE-1:0] data_in;
    logic                      pop;
    logic [FIFO_WORD_SIZE-1:0] data_out;
    logic                      valid_out;
    logic                      empty;
    logic                      full;
    logic                      almostfull;
    logic                      almostempty;
    logic [CW-1:0]             count;
    logic                      error;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, empty, full, almostfull, almostempty, count, error
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, empty, full, almostfull, almostempty, count, error
    );
endinterface

// File: rtl/fifo_puerto.sv
// Circular-buffer FIFO with registered one-cycle read, occupancy flags and a sticky
// overflow/underflow error bit.
module fifo_puerto #(
    parameter int FIFO_WORD_SIZE = 10,
    parameter int FIFO_DEPTH     = 8,
    parameter int ALMOSTFULL_TH  = 6,
    parameter int ALMOSTEMPTY_TH = 2
) (
    input  logic          clk,
    input  logic          reset_L,
    fifo_puerto_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FIFO_WORD_SIZE-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0]             wr_ptr_reg;
    logic [AW-1:0]             rd_ptr_reg;
    logic [CW-1:0]             count_reg;
    logic [CW-1:0]             count_next;
    logic [FIFO_WORD_SIZE-1:0] data_out_reg;
    logic                      valid_reg;
    logic                      error_reg;

    logic empty_w;
    logic full_w;
    logic push_ok;
    logic pop_ok;
    logic overflow;
    logic underflow;

    assign empty_w = (count_reg == '0);
    assign full_w  = (count_reg == CW'(FIFO_DEPTH));

    // A push into a full FIFO is still legal when the same edge frees a slot.
    always_comb begin
        pop_ok    = bus.pop && !empty_w;
        push_ok   = bus.push && (!full_w || pop_ok);
        overflow  = bus.push && !push_ok;
        underflow = bus.pop && empty_w;
    end

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok && reset_L) begin
            mem[wr_ptr_reg] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            valid_reg <= pop_ok;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                data_out_reg <= mem[rd_ptr_reg];
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            end
            if (overflow || underflow) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign bus.data_out    = data_out_reg;
    assign bus.valid_out   = valid_reg;
    assign bus.count       = count_reg;
    assign bus.error       = error_reg;
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.almostfull  = (count_reg >= CW'(ALMOSTFULL_TH));
    assign bus.almostempty = (count_reg <= CW'(ALMOSTEMPTY_TH));
endmodule

// File: tb/tb_fifo_puerto.sv
// Scoreboard bench for fifo_puerto: stimulus queues expected read words, a negedge
// monitor checks every output against a queue-based reference model.
module tb_fifo_puerto;
    localparam int W     = 10;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    fifo_puerto_if #(.FIFO_WORD_SIZE(W), .FIFO_DEPTH(DEPTH)) bus ();

    fifo_puerto #(
        .FIFO_WORD_SIZE(W),
        .FIFO_DEPTH    (DEPTH),
        .ALMOSTFULL_TH (AF),
        .ALMOSTEMPTY_TH(AE)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_q   [$];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] m_last;
    logic         m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_last = '0;
        m_err  = 1'b0;
    endtask

    // One clock of stimulus; the model advances right after the edge.
    task automatic cyc(input logic p, input logic q, input logic [W-1:0] d);
        bit pop_ok, push_ok;
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        pop_ok  = q && (m_q.size() != 0);
        push_ok = p && ((m_q.size() < DEPTH) || pop_ok);
        @(posedge clk);
        if (pop_ok) begin
            m_last = m_q.pop_front();
            exp_q.push_back(m_last);
        end
        if (push_ok) m_q.push_back(d);
        if ((p && !push_ok) || (q && !pop_ok)) m_err = 1'b1;
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        $display("cycle push=%0b pop=%0b din=%03h model_count=%0d", p, q, d, m_q.size());
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset_L = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset_L = 1'b1;
        $display("reset applied");
    endtask

    // Monitor: every output is compared against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_L) begin
                if (bus.valid_out) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 32'(bus.valid_out), 32'd0);
                    end else begin
                        chk("read_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
                    end
                end else if (exp_q.size() != 0) begin
                    chk("missing_valid", 32'(bus.valid_out), 32'd1);
                    void'(exp_q.pop_front());
                end
                chk("count",       32'(bus.count),       32'(m_q.size()));
                chk("empty",       32'(bus.empty),       32'(m_q.size() == 0));
                chk("full",        32'(bus.full),        32'(m_q.size() == DEPTH));
                chk("almostfull",  32'(bus.almostfull),  32'(m_q.size() >= AF));
                chk("almostempty", 32'(bus.almostempty), 32'(m_q.size() <= AE));
                chk("error",       32'(bus.error),       32'(m_err));
                chk("data_hold",   32'(bus.data_out),    32'(m_last));
            end
        end
    end

    initial begin
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        model_reset();
        #12;
        chk("rst_count",  32'(bus.count), 32'd0);
        chk("rst_empty",  32'(bus.empty), 32'd1);
        chk("rst_ae",     32'(bus.almostempty), 32'd1);
        chk("rst_full",   32'(bus.full), 32'd0);
        chk("rst_af",     32'(bus.almostfull), 32'd0);
        chk("rst_valid",  32'(bus.valid_out), 32'd0);
        chk("rst_error",  32'(bus.error), 32'd0);
        chk("rst_dout",   32'(bus.data_out), 32'd0);
        @(posedge clk);
        #2 reset_L = 1'b1;

        // Fill to full with 0x001..0x008.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 10'(i));
        chk("fill_count", 32'(bus.count), 32'd8);
        chk("fill_full",  32'(bus.full), 32'd1);
        chk("fill_af",    32'(bus.almostfull), 32'd1);
        chk("fill_error", 32'(bus.error), 32'd0);

        // Drain in order.
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, '0);
        chk("drain_last", 32'(bus.data_out), 32'h008);
        chk("drain_empty", 32'(bus.empty), 32'd1);
        cyc(1'b0, 1'b0, '0);

        // Overflow, then reset clears the error.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 10'(i + 8'h40));
        cyc(1'b1, 1'b0, 10'h3FF);
        chk("ovf_count", 32'(bus.count), 32'd8);
        chk("ovf_error", 32'(bus.error), 32'd1);
        do_reset();
        #1;
        chk("ovf_rst_error", 32'(bus.error), 32'd0);
        chk("ovf_rst_empty", 32'(bus.empty), 32'd1);

        // Underflow keeps data_out and flags error.
        cyc(1'b1, 1'b0, 10'h2A5);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);
        chk("unf_valid", 32'(bus.valid_out), 32'd0);
        chk("unf_dout",  32'(bus.data_out), 32'h2A5);
        chk("unf_error", 32'(bus.error), 32'd1);

        // Push and pop together on empty: push lands, pop is an underflow.
        do_reset();
        cyc(1'b1, 1'b1, 10'h0C3);
        chk("pp_empty_valid", 32'(bus.valid_out), 32'd0);
        chk("pp_empty_count", 32'(bus.count), 32'd1);
        chk("pp_empty_error", 32'(bus.error), 32'd1);

        // Steady state at count=4 across pointer wraps.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 10'(8'h10 + i));
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 10'(8'h20 + i));
        cyc(1'b0, 1'b0, '0);
        chk("wrap_count", 32'(bus.count), 32'd4);
        chk("wrap_error", 32'(bus.error), 32'd0);
        chk("wrap_dout",  32'(bus.data_out), 32'h02F);

        // Asynchronous reset between edges with count=5 and a word in flight.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 10'(8'h70 + i));
        cyc(1'b1, 1'b1, 10'h075);
        #2 reset_L = 1'b0;
        #1;
        chk("async_count", 32'(bus.count), 32'd0);
        chk("async_valid", 32'(bus.valid_out), 32'd0);
        chk("async_empty", 32'(bus.empty), 32'd1);
        model_reset();
        @(posedge clk);
        #2 reset_L = 1'b1;
        cyc(1'b1, 1'b0, 10'h155);
        cyc(1'b0, 1'b1, '0);
        chk("after_rst_dout",  32'(bus.data_out), 32'h155);
        chk("after_rst_valid", 32'(bus.valid_out), 32'd1);
        cyc(1'b0, 1'b0, '0);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
